// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the multicycle MIPS memory port.
//   mem_state_t         sequencer state encoding (IDLE, BUS, RESP)
//   mem_size_t          access size encoding, matches the core's d_size field
//   MEM_TIMEOUT_DEFAULT default waitrequest abort threshold (used with MEM_TIMEOUT_EN)
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } mem_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian byte-lane handling for one access.
//   i_addr_lo     byte offset within the word
//   i_size        access size
//   i_sext        sign-extend sub-word loads
//   i_wdata       store data, low bits significant
//   i_rdata       raw bus read word
//   o_byteenable  lane enables for the bus
//   o_wdata       store data replicated across lanes
//   o_rdata       selected lane, zero/sign extended
//   o_misalign    access not naturally aligned for its size
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  mem_size_t   i_size,
    input  logic        i_sext,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_byteenable = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = i_rdata;
        o_misalign   = 1'b0;
        case (i_size)
            SIZE_BYTE: begin
                o_byteenable = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_wdata[7:0]}};
                o_rdata      = {{24{i_sext & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_byteenable = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{i_sext & w_half[15]}}, w_half};
                o_misalign   = i_addr_lo[0];
            end
            default: begin
                // Word (and the unused 2'b11 encoding): full lanes, sext ignored.
                o_misalign = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: shares the single MIPS memory port between instruction fetch and
// load/store, driving a waitrequest-style bus and stalling the control FSM meanwhile.
//   clk, rst_n        clock, synchronous active-low reset
//   if_req/if_addr    fetch request (held until if_valid); if_valid/if_instr response
//   d_req/d_we/d_size/d_sext/d_addr/d_wdata  load/store request (held until d_valid)
//   d_valid/d_rdata/d_misalign               load/store response
//   stall             hold the control FSM in its current state
//   bus_err           pulses with the valid on a waitrequest timeout
//   mem_*             bus master interface
// Optional feature: define MEM_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES
// consecutive waitrequest-high cycles; otherwise the bus waits forever and bus_err is 0.
module mem_port_sequencer
    import mips_mem_pkg::*;
#(
    parameter bit          DATA_FIRST     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_sext,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_misalign,
    output logic        stall,
    output logic        bus_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    mem_state_t  r_state, w_state_next;
    logic        r_is_data, r_sext, r_misalign, r_mem_read, r_mem_write;
    mem_size_t   r_size;
    logic [1:0]  r_addr_lo;
    logic [3:0]  r_mem_byteenable;
    logic [31:0] r_mem_address, r_mem_writedata, r_if_instr, r_d_rdata;

    logic        w_any_req, w_pick_data, w_skip_bus, w_sel_sext, w_misalign;
    logic [31:0] w_win_addr, w_wdata_rep, w_rdata_ext;
    logic [1:0]  w_sel_addr_lo;
    mem_size_t   w_sel_size;
    logic [3:0]  w_be;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_bus_err, w_abort;
`endif

    assign w_any_req   = if_req | d_req;
    assign w_pick_data = d_req & (DATA_FIRST | ~if_req);
    assign w_win_addr  = w_pick_data ? d_addr : if_addr;

    // In IDLE the aligner sees the incoming winner; afterwards the latched access, so the
    // same instance serves lane setup and read-data extension.
    always_comb begin
        if (r_state == IDLE) begin
            w_sel_size    = w_pick_data ? mem_size_t'(d_size) : SIZE_WORD;
            w_sel_sext    = w_pick_data & d_sext;
            w_sel_addr_lo = w_win_addr[1:0];
        end else begin
            w_sel_size    = r_size;
            w_sel_sext    = r_sext;
            w_sel_addr_lo = r_addr_lo;
        end
    end

    mem_lane_align u_align (
        .i_addr_lo    (w_sel_addr_lo),
        .i_size       (w_sel_size),
        .i_sext       (w_sel_sext),
        .i_wdata      (d_wdata),
        .i_rdata      (mem_readdata),
        .o_byteenable (w_be),
        .o_wdata      (w_wdata_rep),
        .o_rdata      (w_rdata_ext),
        .o_misalign   (w_misalign)
    );

    // Fetches are never checked for alignment.
    assign w_skip_bus = w_pick_data & w_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        if_valid     = 1'b0;
        d_valid      = 1'b0;
        d_misalign   = 1'b0;
        bus_err      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                stall = w_any_req;
                if (w_any_req) w_state_next = w_skip_bus ? RESP : BUS;
            end
            BUS: begin
                stall = 1'b1;
                if (!mem_waitrequest) begin
                    w_state_next = RESP;
`ifdef MEM_TIMEOUT_EN
                end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_abort      = 1'b1;
                    w_state_next = RESP;
`endif
                end
            end
            RESP: begin
                w_state_next = IDLE;
                if_valid     = ~r_is_data;
                d_valid      = r_is_data;
                d_misalign   = r_is_data & r_misalign;
`ifdef MEM_TIMEOUT_EN
                bus_err      = r_bus_err;
`endif
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_data        <= 1'b0;
            r_sext           <= 1'b0;
            r_misalign       <= 1'b0;
            r_size           <= SIZE_WORD;
            r_addr_lo        <= 2'b00;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= 32'h0;
            r_mem_byteenable <= 4'h0;
            r_mem_writedata  <= 32'h0;
            r_if_instr       <= 32'h0;
            r_d_rdata        <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            r_tmo_cnt        <= '0;
            r_bus_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_is_data  <= w_pick_data;
                        r_size     <= w_sel_size;
                        r_sext     <= w_sel_sext;
                        r_addr_lo  <= w_sel_addr_lo;
                        r_misalign <= w_skip_bus;
`ifdef MEM_TIMEOUT_EN
                        r_bus_err  <= 1'b0;
                        r_tmo_cnt  <= '0;
`endif
                        if (w_skip_bus) begin
                            r_d_rdata <= 32'h0;
                        end else begin
                            r_mem_address    <= {w_win_addr[31:2], 2'b00};
                            r_mem_byteenable <= w_be;
                            r_mem_writedata  <= w_wdata_rep;
                            r_mem_read       <= ~(w_pick_data & d_we);
                            r_mem_write      <= w_pick_data & d_we;
                        end
                    end
                end
                BUS: begin
                    if (!mem_waitrequest) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_mem_read) begin
                            if (r_is_data) r_d_rdata  <= w_rdata_ext;
                            else           r_if_instr <= mem_readdata;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (w_abort) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_bus_err   <= 1'b1;
                        if (r_is_data) r_d_rdata  <= 32'h0;
                        else           r_if_instr <= 32'h0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_byteenable = r_mem_byteenable;
    assign mem_writedata  = r_mem_writedata;
    assign if_instr       = r_if_instr;
    assign d_rdata        = r_d_rdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb_mem_port_sequencer: directed scenarios plus randomized accesses for mem_port_sequencer,
// checked against a lane/extension model written with plain arithmetic.
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_valid, d_req, d_we, d_sext, d_valid, d_misalign, stall, bus_err;
    logic [31:0] if_addr, if_instr, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest;
    logic [3:0]  mem_byteenable;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_sequencer #(
        .DATA_FIRST     (1'b1),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_size          (d_size),
        .d_sext          (d_sext),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_valid         (d_valid),
        .d_rdata         (d_rdata),
        .d_misalign      (d_misalign),
        .stall           (stall),
        .bus_err         (bus_err),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata)
    );

    // Reference: value a load returns after lane selection and extension.
    function automatic logic [31:0] model_load(int sz, logic [1:0] k, bit sx, logic [31:0] rd);
        logic [31:0] v;
        if (sz == 0) begin
            v = (rd >> (int'(k) * 8)) & 32'hFF;
            if (sx && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 1) begin
            v = (rd >> (int'(k[1]) * 16)) & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(int sz, logic [1:0] k);
        if (sz == 0) return 4'(1 << int'(k));
        if (sz == 1) return 4'(3 << (int'(k[1]) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(int sz, logic [31:0] wd);
        if (sz == 0) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (sz == 1) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; d_sext = 0; d_size = 2'b10;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_waitrequest = 0; mem_readdata = 0;
        repeat (3) @(negedge clk);
        n_tests++; if ({mem_read, mem_write, if_valid, d_valid, d_misalign, bus_err, stall} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0", {mem_read, mem_write, if_valid, d_valid, d_misalign, bus_err, stall}); end
        n_tests++; if ({mem_address, mem_writedata, if_instr, d_rdata, mem_byteenable} !== 132'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {mem_address, mem_writedata, if_instr, d_rdata, mem_byteenable}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        if_addr = 32'h40; if_req = 1; mem_waitrequest = 0; mem_readdata = 32'h1234_5678;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0 got %b want 1", stall); end
        @(negedge clk);
        n_tests++; if ({mem_read, mem_write, stall} !== 3'b101) begin n_fail++; $display("FAIL fetch_strobe_c1 got %b want 101", {mem_read, mem_write, stall}); end
        n_tests++; if (mem_address !== 32'h40 || mem_byteenable !== 4'hF) begin n_fail++; $display("FAIL fetch_addr_be got %h/%h want 40/f", mem_address, mem_byteenable); end
        @(negedge clk);
        n_tests++; if ({if_valid, d_valid, stall, mem_read} !== 4'b1000) begin n_fail++; $display("FAIL fetch_valid_c2 got %b want 1000", {if_valid, d_valid, stall, mem_read}); end
        n_tests++; if (if_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL fetch_instr got %h want 12345678", if_instr); end
        if_req = 0;
        @(negedge clk);
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse got %b want 0", if_valid); end
    endtask

    task automatic test_store_byte();
        d_req = 1; d_we = 1; d_size = 2'b00; d_addr = 32'h103; d_wdata = 32'hAB; d_sext = 0;
        @(negedge clk);
        n_tests++; if ({mem_write, mem_read} !== 2'b10) begin n_fail++; $display("FAIL sb_strobe got %b want 10", {mem_write, mem_read}); end
        n_tests++; if (mem_address !== 32'h100 || mem_byteenable !== 4'b1000) begin n_fail++; $display("FAIL sb_addr_be got %h/%b want 100/1000", mem_address, mem_byteenable); end
        n_tests++; if (mem_writedata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata got %h want abababab", mem_writedata); end
        @(negedge clk);
        n_tests++; if ({d_valid, if_valid, d_misalign, mem_write} !== 4'b1000) begin n_fail++; $display("FAIL sb_valid got %b want 1000", {d_valid, if_valid, d_misalign, mem_write}); end
        d_req = 0; d_we = 0;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        for (int s = 1; s >= 0; s--) begin
            d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 32'h101; d_sext = 1'(s);
            mem_readdata = 32'h0000_8000;
            @(negedge clk);
            n_tests++; if (mem_read !== 1'b1 || mem_byteenable !== 4'b0010) begin n_fail++; $display("FAIL lb_strobe got %b/%b want 1/0010", mem_read, mem_byteenable); end
            @(negedge clk);
            n_tests++; if (d_valid !== 1'b1 || d_rdata !== (s == 1 ? 32'hFFFF_FF80 : 32'h0000_0080)) begin n_fail++; $display("FAIL lb_rdata sext=%0d got %b/%h", s, d_valid, d_rdata); end
            d_req = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_misalign();
        d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h102;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mis_stall got %b want 1", stall); end
        @(negedge clk);
        n_tests++; if ({d_valid, d_misalign, mem_read, mem_write} !== 4'b1100) begin n_fail++; $display("FAIL mis_resp got %b want 1100", {d_valid, d_misalign, mem_read, mem_write}); end
        n_tests++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata got %h want 0", d_rdata); end
        d_req = 0;
        @(negedge clk);
        n_tests++; if ({d_valid, d_misalign} !== 2'b00) begin n_fail++; $display("FAIL mis_pulse got %b want 00", {d_valid, d_misalign}); end
    endtask

    task automatic test_priority();
        if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h300;
        mem_waitrequest = 0; mem_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if (mem_address !== 32'h300) begin n_fail++; $display("FAIL prio_first_addr got %h want 300", mem_address); end
        @(negedge clk);
        n_tests++; if ({d_valid, if_valid, stall} !== 3'b100) begin n_fail++; $display("FAIL prio_data_valid got %b want 100", {d_valid, if_valid, stall}); end
        d_req = 0; mem_readdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_tests++; if ({stall, mem_read, if_valid} !== 3'b100) begin n_fail++; $display("FAIL prio_idle got %b want 100", {stall, mem_read, if_valid}); end
        @(negedge clk);
        n_tests++; if (mem_read !== 1'b1 || mem_address !== 32'h200) begin n_fail++; $display("FAIL prio_fetch_bus got %b/%h want 1/200", mem_read, mem_address); end
        @(negedge clk);
        n_tests++; if (if_valid !== 1'b1 || if_instr !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL prio_fetch_valid got %b/%h", if_valid, if_instr); end
        if_req = 0;
        @(negedge clk);
    endtask

    task automatic test_wait_reset();
        d_req = 1; d_we = 1; d_size = 2'b01; d_addr = 32'h0000_0416; d_wdata = 32'h1111_BEEF;
        mem_waitrequest = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++; if ({mem_write, mem_read, mem_address, mem_byteenable, mem_writedata} !== {2'b10, 32'h414, 4'b1100, 32'hBEEF_BEEF}) begin n_fail++; $display("FAIL wait_hold c%0d got %b%b %h %b %h", c, mem_write, mem_read, mem_address, mem_byteenable, mem_writedata); end
        end
        rst_n = 0; d_req = 0; d_we = 0;
        @(negedge clk);
        n_tests++; if ({mem_write, mem_read, d_valid, if_valid} !== 4'b0) begin n_fail++; $display("FAIL wait_reset got %b want 0000", {mem_write, mem_read, d_valid, if_valid}); end
        rst_n = 1; mem_waitrequest = 0;
        @(negedge clk);
        n_tests++; if ({d_valid, if_valid, stall} !== 3'b0) begin n_fail++; $display("FAIL wait_after got %b want 000", {d_valid, if_valid, stall}); end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        if_req = 1; if_addr = 32'h500; mem_waitrequest = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++; if (mem_read !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_hold c%0d got %b/%b want 1/0", c, mem_read, if_valid); end
        end
        @(negedge clk);
        n_tests++; if ({if_valid, bus_err, mem_read} !== 3'b110 || if_instr !== 32'h0) begin n_fail++; $display("FAIL tmo_abort got %b %h want 110 0", {if_valid, bus_err, mem_read}, if_instr); end
        if_req = 0; mem_waitrequest = 0;
        @(negedge clk);
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse got %b want 0", bus_err); end
`endif
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            bit          is_d, we, sx, mis;
            int          sz, waits;
            logic [31:0] a, wd, rd;
            is_d  = 1'($urandom_range(0, 2) != 0);
            we    = is_d & 1'($urandom_range(0, 1));
            sx    = 1'($urandom_range(0, 1));
            sz    = is_d ? int'($urandom_range(0, 2)) : 2;
            a     = $urandom; wd = $urandom; rd = $urandom;
            waits = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
            mis   = is_d && ((sz == 2 && a[1:0] != 0) || (sz == 1 && a[0]));
            if (is_d) begin
                d_req = 1; d_we = we; d_sext = sx; d_size = 2'(sz); d_addr = a; d_wdata = wd;
            end else begin
                if_req = 1; if_addr = a;
            end
            if (!mis) begin
                for (int c = 0; c <= waits; c++) begin
                    @(negedge clk);
                    n_tests++; if ({mem_read, mem_write, stall} !== {~we, we, 1'b1} || mem_address !== {a[31:2], 2'b00} || mem_byteenable !== model_be(sz, a[1:0])) begin n_fail++; $display("FAIL rnd_bus t%0d got %b%b%b %h %b", t, mem_read, mem_write, stall, mem_address, mem_byteenable); end
                    if (we) begin
                        n_tests++; if (mem_writedata !== model_wdata(sz, wd)) begin n_fail++; $display("FAIL rnd_wdata t%0d got %h want %h", t, mem_writedata, model_wdata(sz, wd)); end
                    end
                    mem_waitrequest = (c < waits);
                    mem_readdata    = (c < waits) ? $urandom : rd;
                end
            end
            @(negedge clk);
            n_tests++; if ({if_valid, d_valid, d_misalign, bus_err, stall} !== {~is_d, is_d, mis, 2'b00}) begin n_fail++; $display("FAIL rnd_resp t%0d got %b want %b", t, {if_valid, d_valid, d_misalign, bus_err, stall}, {~is_d, is_d, mis, 2'b00}); end
            if (mis) begin
                n_tests++; if (d_rdata !== 32'h0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL rnd_mis t%0d got %h %b%b", t, d_rdata, mem_read, mem_write); end
            end else if (is_d && !we) begin
                n_tests++; if (d_rdata !== model_load(sz, a[1:0], sx, rd)) begin n_fail++; $display("FAIL rnd_load t%0d got %h want %h", t, d_rdata, model_load(sz, a[1:0], sx, rd)); end
            end else if (!is_d) begin
                n_tests++; if (if_instr !== rd) begin n_fail++; $display("FAIL rnd_fetch t%0d got %h want %h", t, if_instr, rd); end
            end
            if_req = 0; d_req = 0; d_we = 0; mem_waitrequest = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fetch();
        test_store_byte();
        test_load_byte();
        test_misalign();
        test_priority();
        test_wait_reset();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
